// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of requester-side and physical-memory-side signals
//               shared by the two-requester memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-side requester
    logic                  i_read;
    logic [ADDR_W-1:0]     i_address;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_resp;
    // data-side requester
    logic                  d_read;
    logic                  d_write;
    logic [DATA_W/8-1:0]   d_byte_enable;
    logic [ADDR_W-1:0]     d_address;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_resp;
    // physical memory port
    logic                  pmem_read;
    logic                  pmem_write;
    logic [DATA_W/8-1:0]   pmem_byte_enable;
    logic [ADDR_W-1:0]     pmem_address;
    logic [DATA_W-1:0]     pmem_wdata;
    logic [DATA_W-1:0]     pmem_rdata;
    logic                  pmem_resp;

    // arbiter view
    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // requester / memory environment view
    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one physical memory port between the instruction and
//               data requesters, with a transaction watchdog. Optional macro
//               ARB_ROUND_ROBIN_EN alternates grants under contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic                timeout_err
);

    localparam int C_BE_W = DATA_W / 8;
    localparam int C_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_WD_W-1:0] C_WD_LAST =
        C_WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic C_WD_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_SERVE_I = 2'd1;
    localparam logic [1:0] C_SERVE_D = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [DATA_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [C_BE_W-1:0] pmem_be_q, pmem_be_d;
    logic [C_WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;
    logic w_serving;
    logic w_timeout_hit;
    logic w_done;

    assign w_d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // set when the data side won the most recent grant
    logic last_grant_q, last_grant_d;

    assign w_grant_d = w_d_req & (~bus.i_read | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == C_IDLE) begin
            if (w_grant_d) begin
                last_grant_d = 1'b1;
            end else if (w_grant_i) begin
                last_grant_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_req;
`endif

    assign w_grant_i     = bus.i_read & ~w_grant_d;
    assign w_serving     = (state_q == C_SERVE_I) || (state_q == C_SERVE_D);
    // a real response in the expiry cycle wins over the watchdog
    assign w_timeout_hit = C_WD_EN && w_serving && !bus.pmem_resp &&
                           (wd_cnt_q == C_WD_LAST);
    assign w_done        = w_serving && (bus.pmem_resp || w_timeout_hit);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and latched request payload
    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        pmem_be_d      = pmem_be_q;
        case (state_q)
            C_IDLE: begin
                if (w_grant_d) begin
                    state_d        = C_SERVE_D;
                    pmem_write_d   = bus.d_write;
                    pmem_read_d    = bus.d_read & ~bus.d_write;
                    pmem_address_d = bus.d_address;
                    pmem_wdata_d   = bus.d_wdata;
                    pmem_be_d      = bus.d_byte_enable;
                end else if (w_grant_i) begin
                    state_d        = C_SERVE_I;
                    pmem_write_d   = 1'b0;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = bus.i_address;
                    pmem_wdata_d   = '0;
                    pmem_be_d      = {C_BE_W{1'b1}};
                end
            end
            C_SERVE_I, C_SERVE_D: begin
                if (w_done) begin
                    state_d      = C_IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = C_IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wd_cnt_d      = '0;
        timeout_err_d = timeout_err_q | w_timeout_hit;
        if (w_serving && !w_done) begin
            wd_cnt_d = wd_cnt_q + C_WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            pmem_be_q      <= '0;
            wd_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            pmem_be_q      <= pmem_be_d;
            wd_cnt_q       <= wd_cnt_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // outputs: completion is combinational on pmem_resp or watchdog expiry
    always_comb begin
        bus.i_resp  = 1'b0;
        bus.i_rdata = '0;
        bus.d_resp  = 1'b0;
        bus.d_rdata = '0;
        if (w_done && (state_q == C_SERVE_I)) begin
            bus.i_resp  = 1'b1;
            bus.i_rdata = bus.pmem_resp ? bus.pmem_rdata : '0;
        end
        if (w_done && (state_q == C_SERVE_D)) begin
            bus.d_resp  = 1'b1;
            bus.d_rdata = bus.pmem_resp ? bus.pmem_rdata : '0;
        end
        bus.pmem_read        = pmem_read_q;
        bus.pmem_write       = pmem_write_q;
        bus.pmem_address     = pmem_address_q;
        bus.pmem_wdata       = pmem_wdata_q;
        bus.pmem_byte_enable = pmem_be_q;
        timeout_err          = timeout_err_q | w_timeout_hit;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a rule-level
//               arbitration model; a second instance exercises the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk;
    logic rst_n;
    logic terr;
    logic terr_wd;

    int checks = 0;
    int errors = 0;
    bit m_last_d = 1'b0;  // model: data side won the previous grant

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_wd ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .timeout_err (terr)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut_wd (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_wd.slave),
        .timeout_err (terr_wd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // arbitration rule: returns 1 when the data side should win
    function automatic bit pick_d(input bit ireq, input bit dreq);
        if (!dreq) return 1'b0;
        if (!ireq) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic idle_inputs();
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_byte_enable = '0;
        bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 0;
        bus_wd.i_read = 0; bus_wd.i_address = '0;
        bus_wd.d_read = 0; bus_wd.d_write = 0; bus_wd.d_byte_enable = '0;
        bus_wd.d_address = '0; bus_wd.d_wdata = '0;
        bus_wd.pmem_rdata = '0; bus_wd.pmem_resp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        m_last_d = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
             bus.pmem_byte_enable} !== '0) begin
            errors++;
            $display("FAIL reset_pmem: rd=%b wr=%b addr=%h wdata=%h be=%h, required all 0",
                     bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
                     bus.pmem_byte_enable);
        end
        checks++;
        if ({bus.i_resp, bus.d_resp, terr, terr_wd} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_resp: i_resp=%b d_resp=%b terr=%b terr_wd=%b, required 0",
                     bus.i_resp, bus.d_resp, terr, terr_wd);
        end
        @(negedge clk);
        rst_n = 1;
        m_last_d = 0;
        // asynchronous reset in the middle of a data write
        @(negedge clk);
        bus.d_write = 1; bus.d_address = 32'h104; bus.d_wdata = 32'h12345678;
        bus.d_byte_enable = 4'b0011;
        @(negedge clk);
        #1;
        checks++;
        if (bus.pmem_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_write: pmem_write=%b, required 1", bus.pmem_write);
        end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.pmem_write, bus.pmem_address} !== '0) begin
            errors++;
            $display("FAIL reset_async: pmem_write=%b addr=%h, required 0 without a clock edge",
                     bus.pmem_write, bus.pmem_address);
        end
        bus.pmem_resp = 1;
        #1;
        checks++;
        if (bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resp: d_resp=%b, required 0", bus.d_resp);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        m_last_d = 0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.pmem_write, bus.pmem_read, bus.d_resp} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_after: wr=%b rd=%b d_resp=%b, required 0",
                     bus.pmem_write, bus.pmem_read, bus.d_resp);
        end
    endtask

    task automatic test_single_i();
        @(negedge clk);
        bus.i_read = 1; bus.i_address = 32'h60;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_byte_enable, bus.i_resp}
            !== {1'b1, 1'b0, 32'h60, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL single_i_strobe: rd=%b wr=%b addr=%h be=%h i_resp=%b, required 1 0 60 f 0",
                     bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_byte_enable, bus.i_resp);
        end
        bus.pmem_resp = 1; bus.pmem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bus.i_resp, bus.i_rdata, bus.d_resp, bus.d_rdata}
            !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL single_i_resp: i_resp=%b i_rdata=%h d_resp=%b d_rdata=%h, required 1 deadbeef 0 0",
                     bus.i_resp, bus.i_rdata, bus.d_resp, bus.d_rdata);
        end
        m_last_d = 0;
        @(negedge clk);
        bus.i_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
        #1;
        checks++;
        if ({bus.pmem_read, bus.i_resp} !== 2'b00) begin
            errors++;
            $display("FAIL single_i_done: pmem_read=%b i_resp=%b, required 0 0",
                     bus.pmem_read, bus.i_resp);
        end
    endtask

    task automatic test_d_write();
        @(negedge clk);
        bus.d_write = 1; bus.d_address = 32'h104; bus.d_wdata = 32'h12345678;
        bus.d_byte_enable = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata,
                 bus.pmem_byte_enable, bus.d_resp}
                !== {1'b1, 1'b0, 32'h104, 32'h12345678, 4'b0011, 1'b0}) begin
                errors++;
                $display("FAIL d_write_hold[%0d]: wr=%b rd=%b addr=%h wdata=%h be=%b d_resp=%b, required 1 0 104 12345678 0011 0",
                         k, bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata,
                         bus.pmem_byte_enable, bus.d_resp);
            end
        end
        @(negedge clk);
        bus.pmem_resp = 1;
        #1;
        checks++;
        if ({bus.d_resp, bus.i_resp} !== 2'b10) begin
            errors++;
            $display("FAIL d_write_resp: d_resp=%b i_resp=%b, required 1 0", bus.d_resp, bus.i_resp);
        end
        m_last_d = 1;
        @(negedge clk);
        bus.d_write = 0; bus.pmem_resp = 0;
        #1;
        checks++;
        if (bus.pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL d_write_done: pmem_write=%b, required 0", bus.pmem_write);
        end
    endtask

    // both request together; the winner drops after its response
    task automatic test_contention();
        bit first_d;
        logic [AW-1:0] exp_addr;
        first_d = pick_d(1'b1, 1'b1);
        @(negedge clk);
        bus.i_read = 1; bus.i_address = 32'h200;
        bus.d_read = 1; bus.d_address = 32'h300; bus.d_byte_enable = 4'hC;
        for (int t = 0; t < 2; t++) begin
            bit cur_d;
            cur_d = (t == 0) ? first_d : !first_d;
            exp_addr = cur_d ? 32'h300 : 32'h200;
            @(negedge clk);
            #1;
            checks++;
            if ({bus.pmem_read, bus.pmem_address} !== {1'b1, exp_addr}) begin
                errors++;
                $display("FAIL contention_grant[%0d]: rd=%b addr=%h, required 1 %h",
                         t, bus.pmem_read, bus.pmem_address, exp_addr);
            end
            bus.pmem_resp = 1; bus.pmem_rdata = 32'hA000_0000 + t;
            #1;
            checks++;
            if ({bus.d_resp, bus.i_resp} !== {cur_d, !cur_d}) begin
                errors++;
                $display("FAIL contention_resp[%0d]: d_resp=%b i_resp=%b, required %b %b",
                         t, bus.d_resp, bus.i_resp, cur_d, !cur_d);
            end
            m_last_d = cur_d;
            @(negedge clk);
            bus.pmem_resp = 0;
            if (cur_d) bus.d_read = 0; else bus.i_read = 0;
            #1;
            checks++;
            if ({bus.pmem_read, bus.d_resp, bus.i_resp} !== 3'b000) begin
                errors++;
                $display("FAIL contention_idle[%0d]: rd=%b d_resp=%b i_resp=%b, required 0",
                         t, bus.pmem_read, bus.d_resp, bus.i_resp);
            end
        end
    endtask

    // both sides hold their requests across three transactions
    task automatic test_back_to_back();
        do_reset();
        bus.i_read = 1; bus.i_address = 32'h1000;
        bus.d_read = 1; bus.d_address = 32'h2000;
        for (int t = 0; t < 3; t++) begin
            bit cur_d;
            cur_d = pick_d(1'b1, 1'b1);
            @(negedge clk);
            #1;
            checks++;
            if (bus.pmem_address !== (cur_d ? 32'h2000 : 32'h1000)) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: addr=%h, required %h",
                         t, bus.pmem_address, cur_d ? 32'h2000 : 32'h1000);
            end
            bus.pmem_resp = 1;
            #1;
            checks++;
            if ({bus.d_resp, bus.i_resp} !== {cur_d, !cur_d}) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: d_resp=%b i_resp=%b, required %b %b",
                         t, bus.d_resp, bus.i_resp, cur_d, !cur_d);
            end
            m_last_d = cur_d;
            @(negedge clk);
            bus.pmem_resp = 0;
        end
        bus.i_read = 0; bus.d_read = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit ireq, pend_i, pend_d;
            int dk;
            logic [AW-1:0] ia, da;
            logic [DW-1:0] dwd;
            logic [BW-1:0] dbe;
            ireq = 1'($urandom_range(0, 1));
            dk = int'($urandom_range(0, 3));
            if (!ireq && dk == 0) ireq = 1;
            ia = $urandom; da = $urandom; dwd = $urandom; dbe = BW'($urandom);
            @(negedge clk);
            bus.i_read = ireq; bus.i_address = ia;
            bus.d_read = (dk == 1 || dk == 3); bus.d_write = (dk >= 2);
            bus.d_address = da; bus.d_wdata = dwd; bus.d_byte_enable = dbe;
            pend_i = ireq; pend_d = (dk != 0);
            while (pend_i || pend_d) begin
                bit exp_d;
                int lat;
                logic [DW-1:0] rd;
                logic [1+1+AW+BW-1:0] exp_pl;
                exp_d = pick_d(pend_i, pend_d);
                lat = int'($urandom_range(0, 4));
                exp_pl = exp_d ? {dk >= 2, dk == 1, da, dbe} : {1'b0, 1'b1, ia, {BW{1'b1}}};
                @(negedge clk);
                for (int w = 0; w <= lat; w++) begin
                    if (w > 0) @(negedge clk);
                    bus.pmem_rdata = $urandom;
                    #1;
                    checks++;
                    if ({bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_byte_enable,
                         bus.d_resp, bus.i_resp, bus.d_rdata, bus.i_rdata}
                        !== {exp_pl, 2'b00, {(2*DW){1'b0}}}
                        || (exp_d && bus.pmem_wdata !== dwd)) begin
                        errors++;
                        $display("FAIL rand_hold[%0d.%0d]: wr=%b rd=%b addr=%h be=%h wdata=%h resp=%b%b, required payload %h (wdata %h) resp 00",
                                 n, w, bus.pmem_write, bus.pmem_read, bus.pmem_address,
                                 bus.pmem_byte_enable, bus.pmem_wdata, bus.d_resp, bus.i_resp,
                                 exp_pl, dwd);
                    end
                end
                rd = $urandom;
                bus.pmem_rdata = rd; bus.pmem_resp = 1;
                #1;
                checks++;
                if ({bus.d_resp, bus.i_resp, bus.d_rdata, bus.i_rdata}
                    !== {exp_d, !exp_d, exp_d ? rd : 32'h0, exp_d ? 32'h0 : rd}) begin
                    errors++;
                    $display("FAIL rand_resp[%0d]: d_resp=%b i_resp=%b d_rdata=%h i_rdata=%h, required winner %s data %h",
                             n, bus.d_resp, bus.i_resp, bus.d_rdata, bus.i_rdata,
                             exp_d ? "D" : "I", rd);
                end
                m_last_d = exp_d;
                @(negedge clk);
                bus.pmem_resp = 0;
                if (exp_d) begin
                    bus.d_read = 0; bus.d_write = 0; pend_d = 0;
                end else begin
                    bus.i_read = 0; pend_i = 0;
                end
                #1;
                checks++;
                if ({bus.pmem_read, bus.pmem_write, bus.d_resp, bus.i_resp} !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_idle[%0d]: rd=%b wr=%b d_resp=%b i_resp=%b, required 0",
                             n, bus.pmem_read, bus.pmem_write, bus.d_resp, bus.i_resp);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        // response in the expiry cycle counts as a normal completion
        bus_wd.d_read = 1; bus_wd.d_address = 32'h40;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus_wd.pmem_read, bus_wd.d_resp, terr_wd} !== 3'b100) begin
                errors++;
                $display("FAIL wd_edge_wait[%0d]: rd=%b d_resp=%b terr=%b, required 1 0 0",
                         c, bus_wd.pmem_read, bus_wd.d_resp, terr_wd);
            end
        end
        @(negedge clk);
        bus_wd.pmem_resp = 1; bus_wd.pmem_rdata = 32'hCAFE0001;
        #1;
        checks++;
        if ({bus_wd.d_resp, bus_wd.d_rdata, terr_wd} !== {1'b1, 32'hCAFE0001, 1'b0}) begin
            errors++;
            $display("FAIL wd_edge_resp: d_resp=%b d_rdata=%h terr=%b, required 1 cafe0001 0",
                     bus_wd.d_resp, bus_wd.d_rdata, terr_wd);
        end
        @(negedge clk);
        bus_wd.d_read = 0; bus_wd.pmem_resp = 0;
        #1;
        checks++;
        if (terr_wd !== 1'b0) begin
            errors++;
            $display("FAIL wd_edge_sticky: terr=%b, required 0", terr_wd);
        end
        // memory never answers
        @(negedge clk);
        bus_wd.d_read = 1; bus_wd.d_address = 32'h44; bus_wd.pmem_rdata = 32'h55AA55AA;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus_wd.pmem_read, bus_wd.d_resp, terr_wd} !== 3'b100) begin
                errors++;
                $display("FAIL wd_wait[%0d]: rd=%b d_resp=%b terr=%b, required 1 0 0",
                         c, bus_wd.pmem_read, bus_wd.d_resp, terr_wd);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus_wd.d_resp, bus_wd.d_rdata, terr_wd} !== {1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL wd_expire: d_resp=%b d_rdata=%h terr=%b, required 1 0 1",
                     bus_wd.d_resp, bus_wd.d_rdata, terr_wd);
        end
        @(negedge clk);
        bus_wd.d_read = 0;
        #1;
        checks++;
        if ({bus_wd.pmem_read, terr_wd} !== 2'b01) begin
            errors++;
            $display("FAIL wd_after: rd=%b terr=%b, required 0 1", bus_wd.pmem_read, terr_wd);
        end
        // a later successful transaction leaves the flag set
        bus_wd.i_read = 1; bus_wd.i_address = 32'h80;
        @(negedge clk);
        bus_wd.pmem_resp = 1; bus_wd.pmem_rdata = 32'h00001234;
        #1;
        checks++;
        if ({bus_wd.i_resp, bus_wd.i_rdata, terr_wd} !== {1'b1, 32'h1234, 1'b1}) begin
            errors++;
            $display("FAIL wd_sticky_txn: i_resp=%b i_rdata=%h terr=%b, required 1 1234 1",
                     bus_wd.i_resp, bus_wd.i_rdata, terr_wd);
        end
        @(negedge clk);
        bus_wd.i_read = 0; bus_wd.pmem_resp = 0;
        #1;
        checks++;
        if (terr_wd !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky_end: terr=%b, required 1", terr_wd);
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_d_write();
        test_contention();
        test_back_to_back();
        test_random();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
